// File: rtl/hazard3_uart_dtm_apb.sv
`default_nettype none
// ============================================================================
// Module      : hazard3_uart_dtm_apb
// Description : UART debug transport. Parses 8N1 command frames from a host,
//               issues one APB transfer per READ/WRITE command and returns the
//               result bytes over UART.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard3_uart_dtm_apb #(
    parameter int CLKS_PER_BIT = 104,
    parameter int W_DIV        = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        apb_psel,
    output logic        apb_penable,
    output logic        apb_pwrite,
    output logic [7:0]  apb_paddr,
    output logic [31:0] apb_pwdata,
    input  logic [31:0] apb_prdata,
    input  logic        apb_pready,
    input  logic        apb_pslverr
);

    localparam logic [W_DIV-1:0] c_bit_reload  = W_DIV'(CLKS_PER_BIT - 1);
    localparam logic [W_DIV-1:0] c_half_reload = W_DIV'(CLKS_PER_BIT / 2 - 1);
    localparam logic [W_DIV-1:0] c_timer_one   = W_DIV'(1);
    localparam logic [7:0]       c_cmd_read    = 8'h01;
    localparam logic [7:0]       c_cmd_write   = 8'h02;

    typedef enum logic [2:0] {
        ST_CMD    = 3'd0,
        ST_ADDR   = 3'd1,
        ST_WDATA  = 3'd2,
        ST_SETUP  = 3'd3,
        ST_ACCESS = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [1:0]       r_rx_sync;
    logic             w_rx;
    logic             r_rx_prev;
    logic             r_rx_active;
    logic [3:0]       r_rx_bitidx;   // 0 = start bit, 1..8 = data, 9 = stop
    logic [W_DIV-1:0] r_rx_timer;
    logic [7:0]       r_rx_shift;
    logic             r_rx_valid;
    logic             r_rx_ferr;

    logic             r_cmd_write;
    logic [1:0]       r_wcnt;
    logic [7:0]       r_addr_stage;
    logic [23:0]      r_wdata_stage;

    logic             r_tx_busy;
    logic [9:0]       r_tx_shift;
    logic [3:0]       r_tx_bitidx;   // bits still to shift after the current one
    logic [W_DIV-1:0] r_tx_timer;
    logic [39:0]      r_resp_buf;
    logic [2:0]       r_resp_left;
    logic             w_tx_last;

    logic             w_load_resp;
    logic [39:0]      w_resp_data;
    logic [2:0]       w_resp_cnt;

    assign w_rx        = r_rx_sync[1];
    assign uart_tx     = r_tx_busy ? r_tx_shift[0] : 1'b1;
    assign apb_psel    = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign apb_penable = (r_state == ST_ACCESS);
    assign w_tx_last   = r_tx_busy && (r_tx_timer == '0) && (r_tx_bitidx == 4'd0)
                         && (r_resp_left == 3'd0);

    // Receiver: synchronise, detect start edge, sample mid-bit, check stop bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sync   <= 2'b11;
            r_rx_prev   <= 1'b1;
            r_rx_active <= 1'b0;
            r_rx_bitidx <= 4'd0;
            r_rx_timer  <= '0;
            r_rx_shift  <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_rx_ferr   <= 1'b0;
        end else begin
            r_rx_sync  <= {r_rx_sync[0], uart_rx};
            r_rx_prev  <= w_rx;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
            if (!r_rx_active) begin
                if (r_rx_prev && !w_rx) begin
                    r_rx_active <= 1'b1;
                    r_rx_bitidx <= 4'd0;
                    r_rx_timer  <= c_half_reload;
                end
            end else if (r_rx_timer != '0) begin
                r_rx_timer <= r_rx_timer - c_timer_one;
            end else begin
                r_rx_timer <= c_bit_reload;
                if (r_rx_bitidx == 4'd0) begin
                    // A start bit that has gone high again is a glitch
                    if (w_rx) begin
                        r_rx_active <= 1'b0;
                    end else begin
                        r_rx_bitidx <= 4'd1;
                    end
                end else if (r_rx_bitidx <= 4'd8) begin
                    r_rx_shift  <= {w_rx, r_rx_shift[7:1]};
                    r_rx_bitidx <= r_rx_bitidx + 4'd1;
                end else begin
                    r_rx_active <= 1'b0;
                    if (w_rx) begin
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_rx_ferr <= 1'b1;
                    end
                end
            end
        end
    end

    // Protocol state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CMD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and reply construction.
    always_comb begin
        w_state_nxt = r_state;
        w_load_resp = 1'b0;
        w_resp_data = 40'h0;
        w_resp_cnt  = 3'd0;
        case (r_state)
            ST_CMD: begin
                if (r_rx_valid) begin
                    if ((r_rx_shift == c_cmd_read) || (r_rx_shift == c_cmd_write)) begin
                        w_state_nxt = ST_ADDR;
                    end else begin
                        w_state_nxt = ST_RESP;
                        w_load_resp = 1'b1;
                        w_resp_data = {32'h0, 8'hFF};
                        w_resp_cnt  = 3'd1;
                    end
                end
            end
            ST_ADDR: begin
                if (r_rx_ferr) begin
                    w_state_nxt = ST_CMD;
                end else if (r_rx_valid) begin
                    w_state_nxt = r_cmd_write ? ST_WDATA : ST_SETUP;
                end
            end
            ST_WDATA: begin
                if (r_rx_ferr) begin
                    w_state_nxt = ST_CMD;
                end else if (r_rx_valid && (r_wcnt == 2'd3)) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (apb_pready) begin
                    w_state_nxt = ST_RESP;
                    w_load_resp = 1'b1;
                    if (r_cmd_write) begin
                        w_resp_data = {32'h0, 7'h0, apb_pslverr};
                        w_resp_cnt  = 3'd1;
                    end else begin
                        w_resp_data = {7'h0, apb_pslverr, apb_prdata};
                        w_resp_cnt  = 3'd5;
                    end
                end
            end
            ST_RESP: begin
                if (w_tx_last) begin
                    w_state_nxt = ST_CMD;
                end
            end
            default: begin
                w_state_nxt = ST_CMD;
            end
        endcase
    end

    // Frame parser: stage address/data so APB outputs only move when a transfer is committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_write   <= 1'b0;
            r_wcnt        <= 2'd0;
            r_addr_stage  <= 8'h00;
            r_wdata_stage <= 24'h0;
            apb_paddr     <= 8'h00;
            apb_pwdata    <= 32'h0;
            apb_pwrite    <= 1'b0;
        end else begin
            case (r_state)
                ST_CMD: begin
                    if (r_rx_valid) begin
                        r_cmd_write <= (r_rx_shift == c_cmd_write);
                        r_wcnt      <= 2'd0;
                    end
                end
                ST_ADDR: begin
                    if (r_rx_valid) begin
                        if (r_cmd_write) begin
                            r_addr_stage <= r_rx_shift;
                        end else begin
                            apb_paddr  <= r_rx_shift;
                            apb_pwrite <= 1'b0;
                        end
                    end
                end
                ST_WDATA: begin
                    if (r_rx_valid) begin
                        r_wcnt <= r_wcnt + 2'd1;
                        case (r_wcnt)
                            2'd0: r_wdata_stage[7:0]   <= r_rx_shift;
                            2'd1: r_wdata_stage[15:8]  <= r_rx_shift;
                            2'd2: r_wdata_stage[23:16] <= r_rx_shift;
                            default: begin
                                apb_paddr  <= r_addr_stage;
                                apb_pwdata <= {r_rx_shift, r_wdata_stage};
                                apb_pwrite <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Transmitter: sends the reply buffer LSB byte first, bytes back-to-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_busy   <= 1'b0;
            r_tx_shift  <= 10'h3FF;
            r_tx_bitidx <= 4'd0;
            r_tx_timer  <= '0;
            r_resp_buf  <= 40'h0;
            r_resp_left <= 3'd0;
        end else if (w_load_resp) begin
            r_resp_buf  <= w_resp_data;
            r_resp_left <= w_resp_cnt;
        end else if (r_state == ST_RESP) begin
            if (r_tx_busy && (r_tx_timer != '0)) begin
                r_tx_timer <= r_tx_timer - c_timer_one;
            end else if (r_tx_busy && (r_tx_bitidx != 4'd0)) begin
                r_tx_shift  <= {1'b1, r_tx_shift[9:1]};
                r_tx_bitidx <= r_tx_bitidx - 4'd1;
                r_tx_timer  <= c_bit_reload;
            end else if (r_resp_left != 3'd0) begin
                r_tx_shift  <= {1'b1, r_resp_buf[7:0], 1'b0};
                r_resp_buf  <= {8'h00, r_resp_buf[39:8]};
                r_resp_left <= r_resp_left - 3'd1;
                r_tx_bitidx <= 4'd9;
                r_tx_timer  <= c_bit_reload;
                r_tx_busy   <= 1'b1;
            end else begin
                r_tx_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard3_uart_dtm_apb.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard3_uart_dtm_apb
// Description : Self-checking bench for the UART debug transport: directed
//               vector table, hand-written fault/reset sequences, random frames
//               against a frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard3_uart_dtm_apb;

    localparam int CPB = 4;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic        uart_tx;
    logic        apb_psel;
    logic        apb_penable;
    logic        apb_pwrite;
    logic [7:0]  apb_paddr;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_pready;
    logic        apb_pslverr;

    hazard3_uart_dtm_apb #(
        .CLKS_PER_BIT (CPB),
        .W_DIV        (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .uart_rx     (uart_rx),
        .uart_tx     (uart_tx),
        .apb_psel    (apb_psel),
        .apb_penable (apb_penable),
        .apb_pwrite  (apb_pwrite),
        .apb_paddr   (apb_paddr),
        .apb_pwdata  (apb_pwdata),
        .apb_prdata  (apb_prdata),
        .apb_pready  (apb_pready),
        .apb_pslverr (apb_pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        slverr;
        int          waits;       // -1 = random 0..5
        bit          chk_timing;
        int          exp_ntx;
        logic [39:0] exp_tx;      // byte i at [8*i +: 8]
        bit          exp_xfer;
        logic [7:0]  exp_paddr;
        logic [31:0] exp_pwdata;
        logic        exp_pwrite;
    } vec_t;

    typedef struct packed {
        logic [7:0]  a;
        logic [31:0] d;
        logic        w;
    } xfer_t;

    int          n_checks = 0;
    int          n_err    = 0;
    int          cyc      = 0;
    logic [7:0]  tx_q [$];
    int          tx_start_q [$];
    xfer_t       xfer_q [$];
    int          n_setup  = 0;
    logic [31:0] s_rdata  = 32'h0;
    logic        s_slverr = 1'b0;
    int          s_waits  = -1;
    logic [31:0] model_pwdata = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // APB slave with configurable wait states, plus protocol monitor
    logic        pv_psel, pv_pen, pv_done, ok;
    logic [7:0]  cap_a;
    logic [31:0] cap_d;
    logic        cap_w;
    int          w_cnt;
    always @(negedge clk) begin
        if (!rst_n) begin
            apb_pready = 1'b0;
            pv_psel    = 1'b0;
            pv_pen     = 1'b0;
            pv_done    = 1'b0;
        end else begin
            if (apb_psel || pv_psel || apb_penable) begin
                ok = 1'b1;
                if (apb_penable && !apb_psel) ok = 1'b0;
                if (pv_psel && !pv_pen && !(apb_psel && apb_penable)) ok = 1'b0;
                if (pv_done && apb_psel) ok = 1'b0;
                if (apb_psel && !pv_psel && apb_penable) ok = 1'b0;
                if (apb_psel && pv_psel &&
                    (apb_paddr !== cap_a || apb_pwdata !== cap_d || apb_pwrite !== cap_w)) ok = 1'b0;
                check("apb_protocol", {63'h0, ok}, 64'h1);
            end
            if (apb_psel && !pv_psel) begin
                cap_a = apb_paddr;
                cap_d = apb_pwdata;
                cap_w = apb_pwrite;
                n_setup++;
                w_cnt = (s_waits < 0) ? int'($urandom_range(0, 5)) : s_waits;
            end
            pv_done    = 1'b0;
            apb_pready = 1'b0;
            if (apb_psel && apb_penable) begin
                if (w_cnt == 0) begin
                    apb_pready  = 1'b1;
                    apb_prdata  = s_rdata;
                    apb_pslverr = s_slverr;
                    pv_done     = 1'b1;
                    xfer_q.push_back('{a: apb_paddr, d: apb_pwdata, w: apb_pwrite});
                end else begin
                    w_cnt--;
                end
            end
            pv_psel = apb_psel;
            pv_pen  = apb_penable;
        end
    end

    // UART receiver for the DUT's serial output
    initial begin : tx_mon
        int         st;
        logic [7:0] b;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && uart_tx === 1'b0) begin
                st = cyc;
                ab = 0;
                repeat (CPB / 2) @(negedge clk);
                if (uart_tx !== 1'b0 || !rst_n) ab = 1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = uart_tx;
                    if (!rst_n) ab = 1;
                end
                repeat (CPB) @(negedge clk);
                if (!rst_n) ab = 1;
                if (!ab) begin
                    check("tx_stop_bit", {63'h0, uart_tx}, 64'h1);
                    tx_q.push_back(b);
                    tx_start_q.push_back(st);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            uart_rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
    endtask

    function automatic vec_t mk(input logic [7:0] cmd, input logic [7:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic slverr, input int waits, input bit timing,
                                input int ntx, input logic [39:0] etx, input bit xfer,
                                input logic [31:0] epwdata, input logic epwrite);
        vec_t v;
        v.cmd = cmd; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.slverr = slverr; v.waits = waits; v.chk_timing = timing;
        v.exp_ntx = ntx; v.exp_tx = etx; v.exp_xfer = xfer;
        v.exp_paddr = addr; v.exp_pwdata = epwdata; v.exp_pwrite = epwrite;
        return v;
    endfunction

    // Frame-level reference: what the host should observe for one command frame
    function automatic vec_t model_fill(input vec_t v, input logic [31:0] last_wdata);
        vec_t r;
        r = v;
        r.chk_timing = 0;
        r.exp_paddr  = v.addr;
        if (v.cmd == 8'h01) begin
            r.exp_xfer = 1; r.exp_pwdata = last_wdata; r.exp_pwrite = 0;
            r.exp_ntx  = 5; r.exp_tx = {7'h0, v.slverr, v.rdata};
        end else if (v.cmd == 8'h02) begin
            r.exp_xfer = 1; r.exp_pwdata = v.wdata; r.exp_pwrite = 1;
            r.exp_ntx  = 1; r.exp_tx = {39'h0, v.slverr};
        end else begin
            r.exp_xfer = 0; r.exp_pwdata = last_wdata; r.exp_pwrite = 0;
            r.exp_ntx  = 1; r.exp_tx = 40'hFF;
        end
        return r;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int    setups0;
        int    t;
        string nm;
        nm = $sformatf("vec%0d", id);
        tx_q.delete(); tx_start_q.delete(); xfer_q.delete();
        setups0  = n_setup;
        s_rdata  = v.rdata;
        s_slverr = v.slverr;
        s_waits  = v.waits;
        send_byte(v.cmd, 1'b1);
        if (v.cmd == 8'h01) begin
            send_byte(v.addr, 1'b1);
        end else if (v.cmd == 8'h02) begin
            send_byte(v.addr, 1'b1);
            for (int i = 0; i < 4; i++) send_byte(v.wdata[8*i +: 8], 1'b1);
        end
        t = 0;
        while (tx_q.size() < v.exp_ntx && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (12 * CPB) @(negedge clk);
        check({nm, "_ntx"}, 64'(tx_q.size()), 64'(v.exp_ntx));
        for (int i = 0; i < v.exp_ntx; i++) begin
            if (i < tx_q.size())
                check($sformatf("%s_tx%0d", nm, i), {56'h0, tx_q[i]}, {56'h0, v.exp_tx[8*i +: 8]});
        end
        check({nm, "_setups"}, 64'(n_setup - setups0), 64'(v.exp_xfer));
        check({nm, "_xfers"}, 64'(xfer_q.size()), 64'(v.exp_xfer));
        if (v.exp_xfer && xfer_q.size() > 0) begin
            check({nm, "_paddr"},  {56'h0, xfer_q[0].a}, {56'h0, v.exp_paddr});
            check({nm, "_pwdata"}, {32'h0, xfer_q[0].d}, {32'h0, v.exp_pwdata});
            check({nm, "_pwrite"}, {63'h0, xfer_q[0].w}, {63'h0, v.exp_pwrite});
            if (v.exp_pwrite) model_pwdata = v.exp_pwdata;
        end
        if (v.chk_timing) begin
            for (int i = 1; i < tx_start_q.size(); i++)
                check($sformatf("%s_byte_period%0d", nm, i),
                      64'(tx_start_q[i] - tx_start_q[i-1]), 64'(10 * CPB));
        end
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    vec_t vecs [9];

    initial begin : main
        vec_t v;
        int   t;
        int   sel;
        uart_rx     = 1'b1;
        apb_prdata  = 32'h0;
        apb_pslverr = 1'b0;
        apb_pready  = 1'b0;
        rst_n       = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_uart_tx", {63'h0, uart_tx}, 64'h1);
        check("rst_psel", {63'h0, apb_psel}, 64'h0);
        check("rst_penable", {63'h0, apb_penable}, 64'h0);
        check("rst_pwrite", {63'h0, apb_pwrite}, 64'h0);
        check("rst_paddr", {56'h0, apb_paddr}, 64'h0);
        check("rst_pwdata", {32'h0, apb_pwdata}, 64'h0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        //           cmd    addr   wdata         rdata         err  waits tim ntx etx                 xfer pwdata        pwrite
        vecs[0] = mk(8'h02, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3,  0, 1, 40'h00,              1, 32'hDEADBEEF, 1'b1);
        vecs[1] = mk(8'h01, 8'h04, 32'h0,        32'h12345678, 1'b0, -1, 1, 5, 40'h00_12345678,     1, 32'hDEADBEEF, 1'b0);
        vecs[2] = mk(8'h01, 8'hFC, 32'h0,        32'h0,        1'b1, -1, 0, 5, 40'h01_00000000,     1, 32'hDEADBEEF, 1'b0);
        vecs[3] = mk(8'h55, 8'h00, 32'h0,        32'h0,        1'b0, -1, 0, 1, 40'hFF,              0, 32'h0,        1'b0);
        vecs[4] = mk(8'h01, 8'h04, 32'h0,        32'hCAFEF00D, 1'b0, 0,  0, 5, 40'h00_CAFEF00D,     1, 32'hDEADBEEF, 1'b0);
        vecs[5] = mk(8'h02, 8'h20, 32'h11223344, 32'h0,        1'b1, 5,  0, 1, 40'h01,              1, 32'h11223344, 1'b1);
        vecs[6] = mk(8'h00, 8'h00, 32'h0,        32'h0,        1'b0, -1, 0, 1, 40'hFF,              0, 32'h0,        1'b0);
        vecs[7] = mk(8'hFF, 8'h00, 32'h0,        32'h0,        1'b0, -1, 0, 1, 40'hFF,              0, 32'h0,        1'b0);
        vecs[8] = mk(8'h01, 8'h00, 32'h0,        32'hFFFFFFFF, 1'b0, -1, 0, 5, 40'h00_FFFFFFFF,     1, 32'h11223344, 1'b0);
        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Receive faults: short glitch, then a write frame with a bad stop bit
        tx_q.delete(); xfer_q.delete();
        t = n_setup;
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20 * CPB) @(negedge clk);
        check("glitch_no_tx", 64'(tx_q.size()), 64'h0);
        send_byte(8'h02, 1'b1);
        send_byte(8'h30, 1'b1);
        send_byte(8'hAA, 1'b0);
        repeat (20 * CPB) @(negedge clk);
        check("ferr_no_xfer", 64'(xfer_q.size()), 64'h0);
        check("ferr_no_setup", 64'(n_setup - t), 64'h0);
        check("ferr_no_tx", 64'(tx_q.size()), 64'h0);
        run_vec(mk(8'h02, 8'h34, 32'h55AA33CC, 32'h0, 1'b0, -1, 0, 1, 40'h00, 1, 32'h55AA33CC, 1'b1), 100);

        // Reset while the slave stalls the ACCESS phase
        tx_q.delete(); xfer_q.delete();
        s_waits = 1000;
        send_byte(8'h01, 1'b1);
        send_byte(8'h40, 1'b1);
        t = 0;
        while (!(apb_psel && apb_penable) && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("access_reached", {63'h0, apb_psel & apb_penable}, 64'h1);
        rst_n = 1'b0;
        #1;
        check("rst_access_psel", {63'h0, apb_psel}, 64'h0);
        check("rst_access_penable", {63'h0, apb_penable}, 64'h0);
        check("rst_access_tx", {63'h0, uart_tx}, 64'h1);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        model_pwdata = 32'h0;
        s_waits = -1;
        repeat (20 * CPB) @(negedge clk);
        check("rst_access_no_xfer", 64'(xfer_q.size()), 64'h0);
        check("rst_access_no_tx", 64'(tx_q.size()), 64'h0);

        // Reset in the middle of a reply
        s_waits  = 0;
        s_rdata  = 32'h87654321;
        s_slverr = 1'b0;
        send_byte(8'h01, 1'b1);
        send_byte(8'h44, 1'b1);
        t = 0;
        while (uart_tx !== 1'b0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("reply_started", {63'h0, uart_tx}, 64'h0);
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_reply_tx", {63'h0, uart_tx}, 64'h1);
        check("rst_reply_psel", {63'h0, apb_psel}, 64'h0);
        check("rst_reply_pwdata", {32'h0, apb_pwdata}, 64'h0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        model_pwdata = 32'h0;
        s_waits = -1;
        repeat (20 * CPB) @(negedge clk);
        run_vec(mk(8'h01, 8'h08, 32'h0, 32'h0BADF00D, 1'b0, -1, 0, 5, 40'h00_0BADF00D, 1, 32'h0, 1'b0), 101);

        // Random frames against the frame-level model
        for (int i = 0; i < 24; i++) begin
            sel = int'($urandom_range(0, 9));
            v.cmd    = (sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom);
            v.addr   = 8'($urandom);
            v.wdata  = $urandom;
            v.rdata  = $urandom;
            v.slverr = 1'($urandom_range(0, 1));
            v.waits  = -1;
            v = model_fill(v, model_pwdata);
            run_vec(v, 200 + i);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
